// File: rtl/vga_raster_timing.sv
// 1344x804 raster counter with registered syncs, blanking, line retrace and sticky interrupt; one cycle of latency, no backpressure.
// Define VGA_RASTER_NARROW_EN to honour narrow_960 (960-column visible width); otherwise the visible width is fixed at 1024.
module vga_raster_timing (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cli,
    input  logic        enable_interrupt_on_hblank,
    input  logic        enable_interrupt_on_vblank,
    input  logic        narrow_960,
    input  logic        short_frame,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        hsync,
    output logic        vsync,
    output logic        blank,
    output logic        retrace,
    output logic        interrupt
);

    localparam logic [10:0] H_LAST       = 11'd1343;
    localparam logic [10:0] H_VIS        = 11'd1024;
    localparam logic [10:0] H_VIS_NARROW = 11'd960;
    localparam logic [10:0] HS_FIRST     = 11'd1048;
    localparam logic [10:0] HS_LAST      = 11'd1183;
    localparam logic [9:0]  V_VIS        = 10'd768;
    localparam logic [9:0]  VS_FIRST     = 10'd771;
    localparam logic [9:0]  VS_LAST      = 10'd776;
    localparam logic [9:0]  V_LAST       = 10'd803;
    localparam logic [9:0]  V_LAST_SHORT = 10'd797;

    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        blank_q, blank_d;
    logic        retrace_q, retrace_d;
    logic        irq_q, irq_d;
    logic        short_q, short_d;
    logic        line_end;
    logic        frame_end;
    logic [9:0]  v_last;
    logic [10:0] width;
    logic        hblank_ev;
    logic        vblank_ev;

`ifdef VGA_RASTER_NARROW_EN
    logic narrow_q, narrow_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            narrow_q <= 1'b0;
        end else begin
            narrow_q <= narrow_d;
        end
    end

    // Width follows the line being entered, so a change latched at line end applies from x==0 onward.
    always_comb begin
        narrow_d = line_end ? narrow_960 : narrow_q;
        width    = narrow_d ? H_VIS_NARROW : H_VIS;
    end
`else
    logic unused_narrow;
    assign unused_narrow = narrow_960;
    assign width         = H_VIS;
`endif

    // Everything registered is derived from the next position so outputs line up with x/y.
    always_comb begin
        line_end  = (x_q == H_LAST);
        v_last    = short_q ? V_LAST_SHORT : V_LAST;
        frame_end = line_end && (y_q == v_last);

        x_d = line_end ? 11'd0 : x_q + 11'd1;
        y_d = y_q;
        if (frame_end) begin
            y_d = 10'd0;
        end else if (line_end) begin
            y_d = y_q + 10'd1;
        end
        short_d = frame_end ? short_frame : short_q;

        blank_d   = (x_d >= width) || (y_d >= V_VIS);
        hsync_d   = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
        vsync_d   = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
        retrace_d = (x_d == H_LAST);

        hblank_ev = (x_d == width) && (y_d < V_VIS);
        vblank_ev = (x_d == 11'd0) && (y_d == V_VIS);
        // A new event beats a simultaneous clear.
        irq_d = (enable_interrupt_on_hblank && hblank_ev) ||
                (enable_interrupt_on_vblank && vblank_ev) ||
                (irq_q && !cli);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q       <= 11'd0;
            y_q       <= 10'd0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_q   <= 1'b0;
            retrace_q <= 1'b0;
            irq_q     <= 1'b0;
            short_q   <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            blank_q   <= blank_d;
            retrace_q <= retrace_d;
            irq_q     <= irq_d;
            short_q   <= short_d;
        end
    end

    assign x         = x_q;
    assign y         = y_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign blank     = blank_q;
    assign retrace   = retrace_q;
    assign interrupt = irq_q;

endmodule

// File: tb/tb_vga_raster_timing.sv
// Directed bench for vga_raster_timing; long vertical stretches are skipped by forcing the line counter mid-line.
module tb_vga_raster_timing;

`ifdef VGA_RASTER_NARROW_EN
    localparam bit NARROW = 1'b1;
`else
    localparam bit NARROW = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cli;
    logic        en_h;
    logic        en_v;
    logic        narrow_960;
    logic        short_frame;
    logic [10:0] x;
    logic [9:0]  y;
    logic        hsync, vsync, blank, retrace, interrupt;

    int n_checks = 0;
    int n_errors = 0;

    // Bench-side position model
    int ex = 0;
    int ey = 0;
    int mvt = 804;

    vga_raster_timing dut (
        .clk                        (clk),
        .rst_n                      (rst_n),
        .cli                        (cli),
        .enable_interrupt_on_hblank (en_h),
        .enable_interrupt_on_vblank (en_v),
        .narrow_960                 (narrow_960),
        .short_frame                (short_frame),
        .x                          (x),
        .y                          (y),
        .hsync                      (hsync),
        .vsync                      (vsync),
        .blank                      (blank),
        .retrace                    (retrace),
        .interrupt                  (interrupt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (model x=%0d y=%0d)", tag, got, exp, ex, ey);
        end
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (ex == 1343) begin
                ex = 0;
                if (ey == mvt - 1) begin
                    ey  = 0;
                    mvt = short_frame ? 798 : 804;
                end else begin
                    ey = ey + 1;
                end
            end else begin
                ex = ex + 1;
            end
        end
        #1;
    endtask

    task automatic go(input int xt, input int yt);
        int steps;
        steps = (yt - ey) * 1344 + (xt - ex);
        if (steps > 0) adv(steps);
        check_val("pos_x", 32'(x), 32'(xt));
        check_val("pos_y", 32'(y), 32'(yt));
    endtask

    task automatic jump_y(input logic [9:0] yt);
        force dut.y_q = yt;
        adv(1);
        release dut.y_q;
        ey = int'(yt);
        check_val("jump_y", 32'(y), 32'(yt));
    endtask

    int rcount;
    int rconsec;
    logic rprev;

    initial begin
        rst_n = 1'b0; cli = 1'b0; en_h = 1'b0; en_v = 1'b0;
        narrow_960 = 1'b0; short_frame = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_x", 32'(x), 0);
        check_val("rst_y", 32'(y), 0);
        check_val("rst_hsync", 32'(hsync), 1);
        check_val("rst_vsync", 32'(vsync), 1);
        check_val("rst_blank", 32'(blank), 0);
        check_val("rst_retrace", 32'(retrace), 0);
        check_val("rst_irq", 32'(interrupt), 0);

        rst_n = 1'b1;
        ex = 0; ey = 0; mvt = 804;

        // Horizontal timing on line 0
        go(1023, 0);  check_val("blank_1023", 32'(blank), 0);
        adv(1);       check_val("x_1024", 32'(x), 1024);
                      check_val("blank_1024", 32'(blank), 1);
        go(1047, 0);  check_val("hsync_1047", 32'(hsync), 1);
        adv(1);       check_val("hsync_1048", 32'(hsync), 0);
        go(1183, 0);  check_val("hsync_1183", 32'(hsync), 0);
        adv(1);       check_val("hsync_1184", 32'(hsync), 1);
        go(1343, 0);  check_val("retrace_1343", 32'(retrace), 1);
        adv(1);       check_val("wrap_x", 32'(x), 0);
                      check_val("wrap_y", 32'(y), 1);
                      check_val("retrace_0", 32'(retrace), 0);

        // Retrace: one pulse per line, never on consecutive cycles
        rcount = 0; rconsec = 0; rprev = 1'b0;
        for (int i = 0; i < 2688; i++) begin
            adv(1);
            if (retrace) rcount++;
            if (retrace && rprev) rconsec++;
            rprev = retrace;
        end
        check_val("retrace_count", 32'(rcount), 2);
        check_val("retrace_consec", 32'(rconsec), 0);
        go(0, 3);
        check_val("vsync_line3", 32'(vsync), 1);

        // hblank interrupt, sticky through enable drop, cleared by cli
        en_h = 1'b1;
        go(1023, 3);  check_val("irq_before_hb", 32'(interrupt), 0);
        adv(1);       check_val("irq_hb_set", 32'(interrupt), 1);
        en_h = 1'b0;
        adv(10);      check_val("irq_sticky", 32'(interrupt), 1);
        cli = 1'b1;
        adv(1);       check_val("irq_cli", 32'(interrupt), 0);
        cli = 1'b0;

        // Set beats clear at x==W
        en_h = 1'b1;
        go(1024, 4);  check_val("irq_hb_l4", 32'(interrupt), 1);
        go(1023, 5);
        cli = 1'b1;
        adv(1);       check_val("irq_set_wins", 32'(interrupt), 1);
        cli = 1'b0;
        adv(1);       check_val("irq_after_sw", 32'(interrupt), 1);
        go(1030, 5);
        cli = 1'b1;
        adv(1);       check_val("irq_cli_l5", 32'(interrupt), 0);
        cli = 1'b0;
        en_h = 1'b0;

        // Narrow width takes effect on the following line only
        go(500, 6);
        narrow_960 = 1'b1;
        go(960, 6);   check_val("nar_cur_960", 32'(blank), 0);
        go(1024, 6);  check_val("nar_cur_1024", 32'(blank), 1);
        go(959, 7);   check_val("nar_next_959", 32'(blank), 0);
        adv(1);       check_val("nar_next_960", 32'(blank), 32'(NARROW));
        go(1048, 7);  check_val("nar_hsync", 32'(hsync), 0);
        narrow_960 = 1'b0;
        go(1000, 8);  check_val("nar_off_1000", 32'(blank), 0);

        // Vertical blanking, vsync and vblank interrupt
        go(100, 9);
        en_v = 1'b1;
        jump_y(10'd767);
        go(1343, 767);
        check_val("vb_irq_before", 32'(interrupt), 0);
        check_val("vb_blank_1343", 32'(blank), 1);
        adv(1);
        check_val("vb_y768", 32'(y), 768);
        check_val("vb_irq_set", 32'(interrupt), 1);
        check_val("vb_blank_x0", 32'(blank), 1);
        check_val("vb_vsync_768", 32'(vsync), 1);
        go(1343, 770); check_val("vsync_770", 32'(vsync), 1);
        adv(1);        check_val("vsync_771", 32'(vsync), 0);
        go(1343, 776); check_val("vsync_776", 32'(vsync), 0);
                       check_val("retrace_vbl", 32'(retrace), 1);
        adv(1);        check_val("vsync_777", 32'(vsync), 1);
        cli = 1'b1;
        adv(1);        check_val("vb_irq_cli", 32'(interrupt), 0);
        cli = 1'b0;
        en_v = 1'b0;

        // short_frame raised mid-frame: this frame stays 804 lines, next is 798
        short_frame = 1'b1;
        jump_y(10'd800);
        go(1343, 803);
        adv(1);
        check_val("f804_wrap_x", 32'(x), 0);
        check_val("f804_wrap_y", 32'(y), 0);
        check_val("f804_blank", 32'(blank), 0);
        go(5, 0);
        jump_y(10'd795);
        go(1343, 797);
        adv(1);
        check_val("f798_wrap_x", 32'(x), 0);
        check_val("f798_wrap_y", 32'(y), 0);

        // Reset mid-frame restarts counting from the origin
        go(200, 3);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_val("mid_rst_x", 32'(x), 0);
        check_val("mid_rst_y", 32'(y), 0);
        check_val("mid_rst_hsync", 32'(hsync), 1);
        rst_n = 1'b1;
        ex = 0; ey = 0; mvt = 804;
        adv(1);
        check_val("post_rst_x", 32'(x), 1);
        check_val("post_rst_y", 32'(y), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
